// File: rtl/trigger_ctrl_pkg.sv
// Shared types and constants for the trigger configuration controller.
package trigger_ctrl_pkg;

  // Mirrors ADC_RESOLUTION_WIDTH from trigger_config.vh; keep the two in step.
  localparam int ADC_RESOLUTION_WIDTH = 14;
  localparam int TW = ADC_RESOLUTION_WIDTH + 1;

  // Command word field positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int VAL_MSB = 15;

  typedef enum logic [3:0] {
    OP_RISING    = 4'h1,
    OP_FALLING   = 4'h2,
    OP_BASELINE  = 4'h3,
    OP_PRE       = 4'h4,
    OP_POST      = 4'h5,
    OP_ADC_SEL   = 4'h6,
    OP_COMMIT    = 4'hA,
    OP_RUN       = 4'hB,
    OP_HALT      = 4'hC,
    OP_CLR_ERROR = 4'hD
  } opcode_t;

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUNNING,
    ST_DRAIN,
    ST_LOAD
  } state_t;

  // Bit index of each shadow field in the one-hot field select
  localparam int NUM_FIELDS  = 6;
  localparam int FLD_RISING  = 0;
  localparam int FLD_FALLING = 1;
  localparam int FLD_BASE    = 2;
  localparam int FLD_PRE     = 3;
  localparam int FLD_POST    = 4;
  localparam int FLD_ADC_SEL = 5;

endpackage

// File: rtl/trigger_cmd_decode.sv
// Combinational command decode: opcode classification plus value range and
// sign-extension checks. A field select is only raised for a legal write.
module trigger_cmd_decode
  import trigger_ctrl_pkg::*;
#(
  parameter int PRE_W  = 1,
  parameter int POST_W = 1,
  parameter int ADC_W  = 2
) (
  input  logic [31:0]           cmd,
  output logic [NUM_FIELDS-1:0] field_sel,
  output logic                  is_commit,
  output logic                  is_run,
  output logic                  is_halt,
  output logic                  is_clr_error,
  output logic                  legal,
  output logic signed [TW-1:0]  th_value,
  output logic [PRE_W-1:0]      pre_value,
  output logic [POST_W-1:0]     post_value,
  output logic [ADC_W-1:0]      adc_value
);

  logic [3:0]       opc;
  logic [VAL_MSB:0] val;

  // Upper value bits must replicate the threshold sign bit.
  function automatic logic sext_ok(input logic [VAL_MSB:0] v);
    return v[VAL_MSB:TW-1] == {(VAL_MSB - TW + 2){v[TW-1]}};
  endfunction

  // Length values must fit the output width with nothing above it.
  function automatic logic len_ok(input logic [VAL_MSB:0] v, input int w);
    return (v >> w) == '0;
  endfunction

  // Classify the word and qualify writes by their range check.
  always_comb begin
    opc          = cmd[OPC_MSB:OPC_LSB];
    val          = cmd[VAL_MSB:0];
    field_sel    = '0;
    is_commit    = 1'b0;
    is_run       = 1'b0;
    is_halt      = 1'b0;
    is_clr_error = 1'b0;
    legal        = 1'b0;
    th_value     = $signed(val[TW-1:0]);
    pre_value    = val[PRE_W-1:0];
    post_value   = val[POST_W-1:0];
    adc_value    = val[ADC_W-1:0];
    case (opc)
      OP_RISING: begin
        legal                 = sext_ok(val);
        field_sel[FLD_RISING] = legal;
      end
      OP_FALLING: begin
        legal                  = sext_ok(val);
        field_sel[FLD_FALLING] = legal;
      end
      OP_BASELINE: begin
        legal               = sext_ok(val);
        field_sel[FLD_BASE] = legal;
      end
      OP_PRE: begin
        legal              = len_ok(val, PRE_W);
        field_sel[FLD_PRE] = legal;
      end
      OP_POST: begin
        legal               = len_ok(val, POST_W);
        field_sel[FLD_POST] = legal;
      end
      OP_ADC_SEL: begin
        legal                  = len_ok(val, ADC_W);
        field_sel[FLD_ADC_SEL] = legal;
      end
      OP_COMMIT: begin
        legal     = 1'b1;
        is_commit = 1'b1;
      end
      OP_RUN: begin
        legal  = 1'b1;
        is_run = 1'b1;
      end
      OP_HALT: begin
        legal   = 1'b1;
        is_halt = 1'b1;
      end
      OP_CLR_ERROR: begin
        legal        = 1'b1;
        is_clr_error = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/trigger_config_controller.sv
// Run control and configuration sequencer for data_trigger: stages settings in
// shadow registers and, on commit, stops the trigger, loads and strobes them.
module trigger_config_controller
  import trigger_ctrl_pkg::*;
#(
  parameter int MAX_PRE_ACQUISITION_LENGTH      = 2,
  parameter int MAX_POST_ACQUISITION_LENGTH     = 2,
  parameter int MAX_ADC_SELECTION_PERIOD_LENGTH = 4,
  parameter int DRAIN_CYCLES                    = 8
) (
  input  logic                                               ACLK,
  input  logic                                               ARESETN,
  input  logic [31:0]                                        S_AXIS_CMD_TDATA,
  input  logic                                               S_AXIS_CMD_TVALID,
  output logic                                               S_AXIS_CMD_TREADY,
  output logic signed [TW-1:0]                               RISING_EDGE_THRSHOLD,
  output logic signed [TW-1:0]                               FALLING_EDGE_THRESHOLD,
  output logic signed [TW-1:0]                               DIGITAL_BASELINE,
  output logic [$clog2(MAX_PRE_ACQUISITION_LENGTH)-1:0]      PRE_ACQUISITION_LENGTH,
  output logic [$clog2(MAX_POST_ACQUISITION_LENGTH)-1:0]     POST_ACQUISITION_LENGTH,
  output logic [$clog2(MAX_ADC_SELECTION_PERIOD_LENGTH)-1:0] ADC_SELECTION_PERIOD_LENGTH,
  output logic                                               SET_CONFIG,
  output logic                                               STOP,
  output logic                                               CONFIGURED,
  output logic                                               BUSY,
  output logic                                               CMD_ERROR
);

  localparam int PRE_W  = $clog2(MAX_PRE_ACQUISITION_LENGTH);
  localparam int POST_W = $clog2(MAX_POST_ACQUISITION_LENGTH);
  localparam int ADC_W  = $clog2(MAX_ADC_SELECTION_PERIOD_LENGTH);
  localparam int CNT_W  = $clog2(DRAIN_CYCLES + 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        drain_cnt_q;
  logic                    ret_run_q;
  logic                    accept;
  logic                    err_event, clr_err;

  logic [NUM_FIELDS-1:0]   field_sel;
  logic                    is_commit, is_run, is_halt, is_clr_error, legal;
  logic signed [TW-1:0]    th_value;
  logic [PRE_W-1:0]        pre_value;
  logic [POST_W-1:0]       post_value;
  logic [ADC_W-1:0]        adc_value;

  logic signed [TW-1:0]    sh_rising, sh_falling, sh_base;
  logic [PRE_W-1:0]        sh_pre;
  logic [POST_W-1:0]       sh_post;
  logic [ADC_W-1:0]        sh_adc;

  assign accept = S_AXIS_CMD_TVALID & S_AXIS_CMD_TREADY;

  trigger_cmd_decode #(
    .PRE_W  (PRE_W),
    .POST_W (POST_W),
    .ADC_W  (ADC_W)
  ) u_decode (
    .cmd          (S_AXIS_CMD_TDATA),
    .field_sel    (field_sel),
    .is_commit    (is_commit),
    .is_run       (is_run),
    .is_halt      (is_halt),
    .is_clr_error (is_clr_error),
    .legal        (legal),
    .th_value     (th_value),
    .pre_value    (pre_value),
    .post_value   (post_value),
    .adc_value    (adc_value)
  );

  // Next state and error events for the accepted command.
  always_comb begin
    state_d   = state_q;
    err_event = 1'b0;
    clr_err   = 1'b0;
    if (accept) begin
      if (!legal)
        err_event = 1'b1;
      else if (is_clr_error)
        clr_err = 1'b1;
    end
    case (state_q)
      ST_STOPPED: begin
        if (accept && is_commit)
          state_d = ST_LOAD;
        else if (accept && is_run) begin
          if (CONFIGURED)
            state_d = ST_RUNNING;
          else
            err_event = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (accept && is_commit)
          state_d = ST_DRAIN;
        else if (accept && is_halt)
          state_d = ST_STOPPED;
      end
      ST_DRAIN: begin
        if (drain_cnt_q == CNT_W'(1))
          state_d = ST_LOAD;
      end
      ST_LOAD:  state_d = ret_run_q ? ST_RUNNING : ST_STOPPED;
      default:  state_d = ST_STOPPED;
    endcase
  end

  // State, drain counter and registered control outputs (looked ahead from state_d).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q           <= ST_STOPPED;
      drain_cnt_q       <= '0;
      ret_run_q         <= 1'b0;
      STOP              <= 1'b1;
      S_AXIS_CMD_TREADY <= 1'b0;
      BUSY              <= 1'b0;
      SET_CONFIG        <= 1'b0;
      CONFIGURED        <= 1'b0;
      CMD_ERROR         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_RUNNING && state_d == ST_DRAIN)
        drain_cnt_q <= CNT_W'(DRAIN_CYCLES);
      else if (state_q == ST_DRAIN)
        drain_cnt_q <= drain_cnt_q - CNT_W'(1);
      if (state_d == ST_LOAD) begin
        ret_run_q  <= (state_q == ST_DRAIN);
        CONFIGURED <= 1'b1;
      end
      STOP              <= (state_d != ST_RUNNING);
      S_AXIS_CMD_TREADY <= (state_d inside {ST_STOPPED, ST_RUNNING});
      BUSY              <= (state_d inside {ST_DRAIN, ST_LOAD});
      SET_CONFIG        <= (state_d == ST_LOAD);
      if (err_event)
        CMD_ERROR <= 1'b1;
      else if (clr_err)
        CMD_ERROR <= 1'b0;
    end
  end

  // Shadow registers take legal writes only.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      sh_rising  <= '0;
      sh_falling <= '0;
      sh_base    <= '0;
      sh_pre     <= '0;
      sh_post    <= '0;
      sh_adc     <= '0;
    end else if (accept) begin
      if (field_sel[FLD_RISING])  sh_rising  <= th_value;
      if (field_sel[FLD_FALLING]) sh_falling <= th_value;
      if (field_sel[FLD_BASE])    sh_base    <= th_value;
      if (field_sel[FLD_PRE])     sh_pre     <= pre_value;
      if (field_sel[FLD_POST])    sh_post    <= post_value;
      if (field_sel[FLD_ADC_SEL]) sh_adc     <= adc_value;
    end
  end

  // Active settings change only on entry to LOAD, so they are stable with SET_CONFIG.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      RISING_EDGE_THRSHOLD        <= '0;
      FALLING_EDGE_THRESHOLD      <= '0;
      DIGITAL_BASELINE            <= '0;
      PRE_ACQUISITION_LENGTH      <= '0;
      POST_ACQUISITION_LENGTH     <= '0;
      ADC_SELECTION_PERIOD_LENGTH <= '0;
    end else if (state_d == ST_LOAD) begin
      RISING_EDGE_THRSHOLD        <= sh_rising;
      FALLING_EDGE_THRESHOLD      <= sh_falling;
      DIGITAL_BASELINE            <= sh_base;
      PRE_ACQUISITION_LENGTH      <= sh_pre;
      POST_ACQUISITION_LENGTH     <= sh_post;
      ADC_SELECTION_PERIOD_LENGTH <= sh_adc;
    end
  end

endmodule

// File: tb/tb_trigger_config_controller.sv
// Directed bench for trigger_config_controller: stimulus pushes expected loads
// into a scoreboard, a monitor checks every SET_CONFIG pulse against it.
module tb_trigger_config_controller;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [31:0]        tdata = '0;
  logic               tvalid = 1'b0;
  logic               tready;
  logic signed [14:0] rising, falling, baseline;
  logic [0:0]         pre, post;
  logic [1:0]         adc;
  logic               set_config, stop, configured, busy, cmd_error;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [14:0] rise;
    logic [14:0] fall;
    logic [14:0] base;
    logic [0:0]  pre;
    logic [0:0]  post;
    logic [1:0]  adc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  trigger_config_controller #(
    .MAX_PRE_ACQUISITION_LENGTH      (2),
    .MAX_POST_ACQUISITION_LENGTH     (2),
    .MAX_ADC_SELECTION_PERIOD_LENGTH (4),
    .DRAIN_CYCLES                    (8)
  ) dut (
    .ACLK                        (clk),
    .ARESETN                     (rst_n),
    .S_AXIS_CMD_TDATA            (tdata),
    .S_AXIS_CMD_TVALID           (tvalid),
    .S_AXIS_CMD_TREADY           (tready),
    .RISING_EDGE_THRSHOLD        (rising),
    .FALLING_EDGE_THRESHOLD      (falling),
    .DIGITAL_BASELINE            (baseline),
    .PRE_ACQUISITION_LENGTH      (pre),
    .POST_ACQUISITION_LENGTH     (post),
    .ADC_SELECTION_PERIOD_LENGTH (adc),
    .SET_CONFIG                  (set_config),
    .STOP                        (stop),
    .CONFIGURED                  (configured),
    .BUSY                        (busy),
    .CMD_ERROR                   (cmd_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input logic [14:0] r, input logic [14:0] f,
                          input logic [14:0] b, input logic [0:0] p, input logic [0:0] q,
                          input logic [1:0] a);
    exp_t e;
    e.c = c; e.rise = r; e.fall = f; e.base = b; e.pre = p; e.post = q; e.adc = a;
    sb.push_back(e);
  endtask

  // Presents a word from just after a rising edge and holds it until the
  // negedge where TREADY is seen high; returns the accepting cycle. The word
  // stays valid across that edge, so idle() or another send() must follow.
  task automatic send(input logic [31:0] w, output int t);
    int n;
    @(posedge clk); #1;
    tdata = w;
    tvalid = 1'b1;
    n = 0;
    t = -1;
    while (n < 100) begin
      @(negedge clk);
      if (tready) begin
        t = cyc;
        break;
      end
      n++;
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: word %08h not accepted within 100 cycles", w);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    tvalid = 1'b0;
  endtask

  task automatic cmd(input logic [31:0] w, output int t);
    send(w, t);
    idle();
  endtask

  // Monitor: every SET_CONFIG cycle must match the oldest expected load.
  always @(negedge clk) begin
    if (rst_n && set_config) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL set_config_unexpected: actual=pulse required=none (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("load_cycle", 32'(cyc), 32'(mon_e.c));
        chk("load_rising", 32'($unsigned(rising)), 32'(mon_e.rise));
        chk("load_falling", 32'($unsigned(falling)), 32'(mon_e.fall));
        chk("load_baseline", 32'($unsigned(baseline)), 32'(mon_e.base));
        chk("load_pre", 32'(pre), 32'(mon_e.pre));
        chk("load_post", 32'(post), 32'(mon_e.post));
        chk("load_adc", 32'(adc), 32'(mon_e.adc));
        chk("load_stop", 32'(stop), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t3;
    logic [31:0] bad_words [5];
    bad_words[0] = 32'h4000_0002;  // pre=2 exceeds 1-bit width
    bad_words[1] = 32'h7000_0000;  // undefined opcode
    bad_words[2] = 32'h1000_4000;  // rising: bit14 set, bit15 clear
    bad_words[3] = 32'h2000_8000;  // falling: bit15 set, bit14 clear
    bad_words[4] = 32'h6000_0004;  // adc select 4 exceeds 2-bit width

    // Reset values
    @(negedge clk);
    chk("rst_stop", 32'(stop), 32'd1);
    chk("rst_tready", 32'(tready), 32'd0);
    chk("rst_set_config", 32'(set_config), 32'd0);
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_error", 32'(cmd_error), 32'd0);
    chk("rst_rising", 32'($unsigned(rising)), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_tready", 32'(tready), 32'd1);

    // RUN before any commit is an error; CLR_ERROR clears it
    cmd(32'hB000_0000, t);
    @(negedge clk);
    chk("run_unconfigured_err", 32'(cmd_error), 32'd1);
    chk("run_unconfigured_stop", 32'(stop), 32'd1);
    cmd(32'hD000_0000, t);
    @(negedge clk);
    chk("clr_error", 32'(cmd_error), 32'd0);

    // Commit from STOPPED: load visible the cycle after acceptance
    cmd(32'h1000_0100, t);
    cmd(32'h4000_0001, t);
    send(32'hA000_0000, t);
    push_exp(t + 1, 15'h0100, 15'h0000, 15'h0000, 1'b1, 1'b0, 2'd0);
    idle();
    @(negedge clk);
    chk("stopped_load_stop", 32'(stop), 32'd1);
    chk("stopped_load_tready", 32'(tready), 32'd0);
    chk("stopped_load_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("stopped_after_tready", 32'(tready), 32'd1);
    chk("stopped_after_busy", 32'(busy), 32'd0);
    chk("stopped_after_configured", 32'(configured), 32'd1);
    chk("stopped_after_set_config", 32'(set_config), 32'd0);

    // RUN, then commit while running: 8-cycle drain, load at t+9, run at t+10
    cmd(32'hB000_0000, t);
    @(negedge clk);
    chk("run_stop_low", 32'(stop), 32'd0);
    cmd(32'h2000_FF80, t);
    send(32'hA000_0000, t);
    push_exp(t + 9, 15'h0100, 15'h7F80, 15'h0000, 1'b1, 1'b0, 2'd0);
    idle();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("drain_stop_%0d", k), 32'(stop), 32'd1);
      chk($sformatf("drain_tready_%0d", k), 32'(tready), 32'd0);
      chk($sformatf("drain_busy_%0d", k), 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("drain_done_stop", 32'(stop), 32'd0);
    chk("drain_done_tready", 32'(tready), 32'd1);
    chk("drain_done_busy", 32'(busy), 32'd0);

    // HALT while running
    cmd(32'hC000_0000, t);
    @(negedge clk);
    chk("halt_stop", 32'(stop), 32'd1);

    // Illegal words flag an error and leave the shadow untouched
    foreach (bad_words[i]) begin
      cmd(bad_words[i], t);
      @(negedge clk);
      chk($sformatf("bad_word_%0d_err", i), 32'(cmd_error), 32'd1);
      cmd(32'hD000_0000, t);
      @(negedge clk);
      chk($sformatf("bad_word_%0d_clr", i), 32'(cmd_error), 32'd0);
    end
    cmd(32'h3000_3FFF, t);
    cmd(32'h5000_0001, t);
    cmd(32'h6000_0003, t);
    @(negedge clk);
    chk("legal_writes_no_err", 32'(cmd_error), 32'd0);
    chk("shadow_not_active", 32'($unsigned(baseline)), 32'd0);
    send(32'hA000_0000, t);
    push_exp(t + 1, 15'h0100, 15'h7F80, 15'h3FFF, 1'b1, 1'b1, 2'd3);
    idle();
    repeat (2) @(negedge clk);

    // Reset asserted in the middle of a drain
    cmd(32'hB000_0000, t);
    cmd(32'h1000_0055, t);
    send(32'hA000_0000, t);
    idle();
    repeat (3) @(negedge clk);
    chk("mid_drain_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stop", 32'(stop), 32'd1);
    chk("async_rst_set_config", 32'(set_config), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_tready", 32'(tready), 32'd0);
    chk("async_rst_configured", 32'(configured), 32'd0);
    chk("async_rst_rising", 32'($unsigned(rising)), 32'd0);
    chk("async_rst_falling", 32'($unsigned(falling)), 32'd0);
    chk("async_rst_baseline", 32'($unsigned(baseline)), 32'd0);
    chk("async_rst_adc", 32'(adc), 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("after_rst_stop", 32'(stop), 32'd1);
    chk("after_rst_rising", 32'($unsigned(rising)), 32'd0);
    chk("after_rst_configured", 32'(configured), 32'd0);

    // Back-to-back words held during a drain are accepted in order afterwards
    cmd(32'h4000_0001, t);
    send(32'hA000_0000, t);
    push_exp(t + 1, 15'h0000, 15'h0000, 15'h0000, 1'b1, 1'b0, 2'd0);
    idle();
    cmd(32'hB000_0000, t);
    send(32'hA000_0000, t);
    push_exp(t + 9, 15'h0000, 15'h0000, 15'h0000, 1'b1, 1'b0, 2'd0);
    send(32'h1000_0011, t2);
    send(32'h2000_0022, t3);
    idle();
    chk("b2b_first_accept", 32'(t2 - t), 32'd10);
    chk("b2b_second_accept", 32'(t3 - t), 32'd11);
    @(negedge clk);
    chk("b2b_running", 32'(stop), 32'd0);
    cmd(32'hC000_0000, t);
    send(32'hA000_0000, t);
    push_exp(t + 1, 15'h0011, 15'h0022, 15'h0000, 1'b1, 1'b0, 2'd0);
    idle();
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
